shift_sequencer: RTL

//  Multi-cycle shift/rotate engine feeding the ALU writeback path for counted group-2 ops (by CL or imm8).

---
 rtl/shift_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Counted group-2 shift/rotate engine, one bit per clock, with ALU
//            flag vector {Z,S,P,V,CY,AC} for the PSW writeback path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
  parameter int COUNT_BITS = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        size,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  input  logic        cy_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [5:0]  flags,
  output logic        flags_update
);

  localparam logic [2:0] c_op_rol  = 3'd0;
  localparam logic [2:0] c_op_ror  = 3'd1;
  localparam logic [2:0] c_op_rolc = 3'd2;
  localparam logic [2:0] c_op_rorc = 3'd3;
  localparam logic [2:0] c_op_shl  = 3'd4;
  localparam logic [2:0] c_op_shr  = 3'd5;
  localparam logic [2:0] c_op_shra = 3'd6;
  localparam logic [2:0] c_op_rsvd = 3'd7;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic                    size_q, size_d;
  logic [15:0]             data_q, data_d;
  logic                    carry_q, carry_d;
  logic                    orig_msb_q, orig_msb_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             result_q, result_d;
  logic [5:0]              flags_q, flags_d;
  logic                    fupd_q, fupd_d;

  logic [15:0]             w_step_d;
  logic                    w_step_c;

  generate
    if (COUNT_BITS < 8) begin : g_count_hi
      logic w_unused_count_hi;
      assign w_unused_count_hi = ^count[7:COUNT_BITS];
    end
  endgenerate

  // Flag vector from the final data/carry; zero-count ops force V low.
  function automatic logic [5:0] calc_flags(
    input logic [15:0] d,
    input logic        c,
    input logic        sz,
    input logic [2:0]  o,
    input logic        orig_msb,
    input logic        zero_cnt
  );
    logic msb, nxt, v, z;
    msb = sz ? d[15] : d[7];
    nxt = sz ? d[14] : d[6];
    z   = sz ? (d == 16'h0000) : (d[7:0] == 8'h00);
    case (o)
      c_op_rol, c_op_rolc, c_op_shl: v = msb ^ c;
      c_op_ror, c_op_rorc:           v = msb ^ nxt;
      c_op_shr:                      v = orig_msb;
      default:                       v = 1'b0;
    endcase
    if (zero_cnt) v = 1'b0;
    return {z, msb, ~^d[7:0], v, c, 1'b0};
  endfunction

  // Single-bit step; byte mode only touches bits 7:0 so 15:8 stay as latched.
  always_comb begin
    w_step_d = data_q;
    w_step_c = carry_q;
    if (size_q) begin
      case (op_q)
        c_op_rol:  begin w_step_c = data_q[15]; w_step_d = {data_q[14:0], data_q[15]}; end
        c_op_ror:  begin w_step_c = data_q[0];  w_step_d = {data_q[0], data_q[15:1]};  end
        c_op_rolc: begin w_step_c = data_q[15]; w_step_d = {data_q[14:0], carry_q};    end
        c_op_rorc: begin w_step_c = data_q[0];  w_step_d = {carry_q, data_q[15:1]};    end
        c_op_shl:  begin w_step_c = data_q[15]; w_step_d = {data_q[14:0], 1'b0};       end
        c_op_shr:  begin w_step_c = data_q[0];  w_step_d = {1'b0, data_q[15:1]};       end
        c_op_shra: begin w_step_c = data_q[0];  w_step_d = {data_q[15], data_q[15:1]}; end
        default:   begin w_step_c = carry_q;    w_step_d = data_q;                     end
      endcase
    end else begin
      case (op_q)
        c_op_rol:  begin w_step_c = data_q[7]; w_step_d[7:0] = {data_q[6:0], data_q[7]}; end
        c_op_ror:  begin w_step_c = data_q[0]; w_step_d[7:0] = {data_q[0], data_q[7:1]}; end
        c_op_rolc: begin w_step_c = data_q[7]; w_step_d[7:0] = {data_q[6:0], carry_q};   end
        c_op_rorc: begin w_step_c = data_q[0]; w_step_d[7:0] = {carry_q, data_q[7:1]};   end
        c_op_shl:  begin w_step_c = data_q[7]; w_step_d[7:0] = {data_q[6:0], 1'b0};      end
        c_op_shr:  begin w_step_c = data_q[0]; w_step_d[7:0] = {1'b0, data_q[7:1]};      end
        c_op_shra: begin w_step_c = data_q[0]; w_step_d[7:0] = {data_q[7], data_q[7:1]}; end
        default:   begin w_step_c = carry_q;   w_step_d      = data_q;                   end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    size_d     = size_q;
    data_d     = data_q;
    carry_d    = carry_q;
    orig_msb_d = orig_msb_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    flags_d    = flags_q;
    fupd_d     = fupd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          op_d       = op;
          size_d     = size;
          data_d     = operand;
          carry_d    = cy_in;
          orig_msb_d = size ? operand[15] : operand[7];
          cnt_d      = count[COUNT_BITS-1:0];
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        if ((cnt_q == '0) || (op_q == c_op_rsvd)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          fupd_d   = 1'b0;
          result_d = data_q;
          flags_d  = calc_flags(data_q, carry_q, size_q, op_q, orig_msb_q, 1'b1);
        end else begin
          data_d  = w_step_d;
          carry_d = w_step_c;
          cnt_d   = cnt_q - COUNT_BITS'(1);
          if (cnt_q == COUNT_BITS'(1)) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            fupd_d   = 1'b1;
            result_d = w_step_d;
            flags_d  = calc_flags(w_step_d, w_step_c, size_q, op_q, orig_msb_q, 1'b0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      size_q     <= 1'b0;
      data_q     <= 16'h0000;
      carry_q    <= 1'b0;
      orig_msb_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 16'h0000;
      flags_q    <= 6'h00;
      fupd_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      size_q     <= size_d;
      data_q     <= data_d;
      carry_q    <= carry_d;
      orig_msb_q <= orig_msb_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      fupd_q     <= fupd_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign flags        = flags_q;
  assign flags_update = fupd_q;

endmodule

`default_nettype wire
